scemi_msg_out_packer: RTL and testbench
=======================================

Name: scemi_msg_out_packer

Overview:
- Sits directly upstream of the SCE-MI message output port, in the uncontrolled-clock domain.
- Accepts a stream of DataWidth-bit words from the transactor with valid/ready.
- Packs WordsPerMsg words into one message with a valid-word count in the top byte, and buffers messages in a small FIFO.
- Presents messages on the TransmitReady/ReceiveReady/Message handshake that the output port consumes; a flush request emits partially filled messages.

Parameters:
- DataWidth, 32, width of one input word.
- WordsPerMsg, 4, words per message; range 1..255.
- FifoDepth, 4, message FIFO entries; power of 2, minimum 2.
- PortWidth, DataWidth*WordsPerMsg+8, Message width; must equal this value and is not overridden independently.

Ports:
- Uclock  input  1  uncontrolled clock; all state on rising edge.
- Ureset  input  1  asynchronous active-low reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  DataWidth  input word.
- flush  input  1  single-cycle request to emit the current partial message.
- TransmitReady  output  1  Message holds a valid message.
- ReceiveReady  input  1  downstream port accepts Message this cycle.
- Message  output  PortWidth  head message; [PortWidth-1 -: 8] = valid word count, word k at [k*DataWidth +: DataWidth].
- fifo_level  output  clog2(FifoDepth)+1  number of buffered messages.

Behaviour:
- Reset (Ureset low, asynchronous):
  - fill=0, flush_pending=0, FIFO empty, all storage zeroed.
  - Outputs: TransmitReady=0, Message=0, fifo_level=0, in_ready=1.
  - Reset mid-operation discards all partial and buffered messages.
- Input accept: a word is taken when in_valid && in_ready.
  - The word is stored in slot fill of the packer register and fill increments.
  - Unfilled slots of a message are zero.
- Completion: when the accepted word makes fill==WordsPerMsg, the message is pushed into the FIFO on the same edge.
  - The pushed message has count=WordsPerMsg.
  - fill returns to 0 and the packer register clears.
- in_ready = !flush_pending && !(fill==WordsPerMsg-1 && fifo_full).
  - fifo_full is registered state only; in_ready has no combinational path from ReceiveReady.
  - When WordsPerMsg=1, in_ready = !flush_pending && !fifo_full.
- Flush:
  - A flush pulse sets flush_pending on the next edge.
  - A word accepted in the same cycle as the flush pulse belongs to the flushed message.
  - While flush_pending and fill>0 and !fifo_full, the partial message is pushed with count=fill; fill clears and flush_pending clears on that edge.
  - flush_pending with fill==0 clears the next edge and emits nothing.
  - flush while already pending has no additional effect.
- Output handshake:
  - FIFO is show-ahead: TransmitReady = !fifo_empty, and Message = head entry (registered storage, no combinational logic from inputs).
  - Pop when TransmitReady && ReceiveReady.
  - Message and TransmitReady are stable while TransmitReady=1 and ReceiveReady=0.
  - When not valid, Message holds its last value or 0; receivers ignore it.
- Simultaneous push and pop:
  - Allowed when the FIFO is non-full; fifo_level is unchanged.
  - When full, push is blocked (in_ready/flush emission gated) even if a pop occurs that cycle; the push proceeds the following cycle.
- Latency: from acceptance of the completing word to TransmitReady=1 is 1 edge when the FIFO was empty.
- Pointers wrap modulo FifoDepth; fifo_level ranges 0..FifoDepth.
- No data is ever dropped or overwritten.

Test Plan:
- Basic packing (defaults): 4 words 0x11,0x22,0x33,0x44 with ReceiveReady=1 -> one cycle after the 4th accept, TransmitReady=1 and Message={8'd4,0x44,0x33,0x22,0x11}; popped next edge; fifo_level returns to 0.
- Backpressure: ReceiveReady=0, stream 20 words -> 4 messages buffered, fifo_level=4, in_ready=0 with fill=3 after word 19. Raise ReceiveReady -> messages appear in order, Message stable while stalled, word 20 accepted after the first pop.
- Flush partial: 2 words 0xA,0xB then flush -> Message={8'd2,32'h0,32'h0,0xB,0xA}; in_ready low while flush_pending. Flush with fill=0 -> nothing emitted, flush_pending clears after 1 cycle.
- Flush with word in the same cycle: fill=1 (0x5), in_valid with 0x6 and flush together -> one message with count=2 containing 0x5,0x6.
- Full FIFO with simultaneous pop: FIFO full, fill=3, in_valid=1, ReceiveReady=1 -> that cycle in_ready=0, pop occurs, fifo_level=3; next cycle the word is accepted and fifo_level returns to 4.
- Async reset mid-stream: assert Ureset low between edges with 3 messages buffered and fill=2 -> immediately TransmitReady=0, Message=0, fifo_level=0, in_ready=1; after release, a fresh 4-word sequence produces count=4 with no stale words.

Source files
------------

// File: rtl/scemi_msg_out_packer.sv
// Packs transactor words into SCE-MI output messages, with a flush path for
// partial messages and a show-ahead message FIFO in front of the output port.
module scemi_msg_out_packer #(
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned WordsPerMsg = 4,
  parameter int unsigned FifoDepth   = 4,
  parameter int unsigned PortWidth   = DataWidth * WordsPerMsg + 8
) (
  input  logic                         Uclock,
  input  logic                         Ureset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DataWidth-1:0]         in_data,
  input  logic                         flush,
  output logic                         TransmitReady,
  input  logic                         ReceiveReady,
  output logic [PortWidth-1:0]         Message,
  output logic [$clog2(FifoDepth):0]   fifo_level
);

  localparam int unsigned PackW  = DataWidth * WordsPerMsg;
  localparam int unsigned AddrW  = $clog2(FifoDepth);
  localparam int unsigned LevelW = AddrW + 1;
  localparam int unsigned FillW  = 8;

  logic [PackW-1:0]     pack_q;
  logic [FillW-1:0]     fill_q;
  logic                 flush_pending_q;
  logic [PortWidth-1:0] mem_q [FifoDepth];
  logic [AddrW-1:0]     wr_ptr_q;
  logic [AddrW-1:0]     rd_ptr_q;
  logic [LevelW-1:0]    level_q;

  logic                 fifo_full;
  logic                 last_slot;
  logic                 accept;
  logic                 complete;
  logic                 flush_emit;
  logic                 push;
  logic                 pop;
  logic [PackW-1:0]     pack_c;
  logic [PortWidth-1:0] push_msg;

  // Handshake and push/pop decisions, all from registered state plus inputs
  always_comb begin
    fifo_full  = (level_q == LevelW'(FifoDepth));
    last_slot  = (fill_q == FillW'(WordsPerMsg - 1));
    in_ready   = !flush_pending_q && !(last_slot && fifo_full);
    accept     = in_valid && in_ready;
    complete   = accept && last_slot;
    flush_emit = flush_pending_q && (fill_q != '0) && !fifo_full;
    push       = complete || flush_emit;
    pop        = TransmitReady && ReceiveReady;
  end

  // Packer register with the incoming word dropped into slot fill
  always_comb begin
    pack_c = pack_q;
    for (int k = 0; k < int'(WordsPerMsg); k++) begin
      if (accept && (fill_q == FillW'(k))) begin
        pack_c[k*DataWidth +: DataWidth] = in_data;
      end
    end
    push_msg = {(complete ? FillW'(WordsPerMsg) : fill_q), pack_c};
  end

  // Show-ahead outputs straight from FIFO storage
  always_comb begin
    TransmitReady = (level_q != '0);
    Message       = mem_q[rd_ptr_q];
    fifo_level    = level_q;
  end

  // Packer fill state and flush request tracking
  always_ff @(posedge Uclock or negedge Ureset) begin
    if (!Ureset) begin
      pack_q          <= '0;
      fill_q          <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      if (push) begin
        pack_q <= '0;
        fill_q <= '0;
      end else begin
        pack_q <= pack_c;
        if (accept) fill_q <= fill_q + FillW'(1);
      end
      // A pending flush retires once the partial message is out, or at once if empty
      if (flush_pending_q) begin
        if ((fill_q == '0) || flush_emit) flush_pending_q <= 1'b0;
      end else begin
        flush_pending_q <= flush;
      end
    end
  end

  // Message FIFO storage, pointers and occupancy
  always_ff @(posedge Uclock or negedge Ureset) begin
    if (!Ureset) begin
      for (int i = 0; i < int'(FifoDepth); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_msg;
        wr_ptr_q        <= wr_ptr_q + AddrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AddrW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LevelW'(1);
        2'b01:   level_q <= level_q - LevelW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: tb/tb_scemi_msg_out_packer.sv
// Scoreboard bench for scemi_msg_out_packer at default parameters.
module tb_scemi_msg_out_packer;

  localparam int PW = 136;

  logic          Uclock = 1'b0;
  logic          Ureset;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          flush;
  logic          TransmitReady;
  logic          ReceiveReady;
  logic [PW-1:0] Message;
  logic [2:0]    fifo_level;

  int n_tests = 0;
  int n_fail  = 0;

  logic [PW-1:0] exp_q [$];
  logic [31:0]   m_words [4];
  int            m_fill = 0;

  logic          stall_prev = 1'b0;
  logic [PW-1:0] msg_prev;

  scemi_msg_out_packer dut (
    .Uclock        (Uclock),
    .Ureset        (Ureset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .flush         (flush),
    .TransmitReady (TransmitReady),
    .ReceiveReady  (ReceiveReady),
    .Message       (Message),
    .fifo_level    (fifo_level)
  );

  always #5 Uclock = ~Uclock;

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected message from the bench's own word record, then start a new one
  function automatic void push_exp(input int cnt);
    logic [PW-1:0] m;
    m = '0;
    m[PW-1 -: 8] = 8'(cnt);
    for (int k = 0; k < cnt; k++) m[k*32 +: 32] = m_words[k];
    exp_q.push_back(m);
    m_fill = 0;
    for (int k = 0; k < 4; k++) m_words[k] = '0;
  endfunction

  function automatic void model_accept(input logic [31:0] d);
    m_words[m_fill] = d;
    m_fill++;
    if (m_fill == 4) push_exp(4);
  endfunction

  function automatic void model_flush();
    if (m_fill > 0) push_exp(m_fill);
  endfunction

  // Output monitor: in-order scoreboard compare and stall stability
  always @(negedge Uclock) begin
    if (Ureset) begin
      if (stall_prev) begin
        check("stall_tr", PW'(TransmitReady), PW'(1'b1));
        check("stall_msg", Message, msg_prev);
      end
      if (TransmitReady && ReceiveReady) begin
        if (exp_q.size() == 0) check("unexpected_msg", Message, '0);
        else check("sb_msg", Message, exp_q.pop_front());
      end
      stall_prev = TransmitReady && !ReceiveReady;
      msg_prev   = Message;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Offer one word and hold it until accepted (bounded)
  task automatic send_word(input logic [31:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge Uclock);
    while (!in_ready && n < 200) begin
      @(negedge Uclock);
      n++;
    end
    check("in_ready_wait", PW'(in_ready), PW'(1'b1));
    if (in_ready) begin
      @(posedge Uclock);
      model_accept(d);
    end
    #1 in_valid = 1'b0;
  endtask

  // Let the port drain every buffered message (bounded)
  task automatic drain();
    int n;
    n = 0;
    ReceiveReady = 1'b1;
    while ((exp_q.size() != 0 || TransmitReady) && n < 100) begin
      @(posedge Uclock);
      #1 n++;
    end
    check("drain_sb_empty", PW'(exp_q.size() == 0), PW'(1'b1));
    check("drain_level", PW'(fifo_level), PW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 4; k++) m_words[k] = '0;
    Ureset       = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    flush        = 1'b0;
    ReceiveReady = 1'b0;
    repeat (2) @(posedge Uclock);
    #1;
    check("rst_tr", PW'(TransmitReady), PW'(0));
    check("rst_msg", Message, '0);
    check("rst_level", PW'(fifo_level), PW'(0));
    check("rst_ready", PW'(in_ready), PW'(1));
    #2 Ureset = 1'b1;
    @(posedge Uclock);
    #1;

    // Basic packing with one-edge latency
    ReceiveReady = 1'b1;
    send_word(32'h11);
    send_word(32'h22);
    send_word(32'h33);
    send_word(32'h44);
    check("basic_tr", PW'(TransmitReady), PW'(1));
    check("basic_msg", Message, {8'd4, 32'h44, 32'h33, 32'h22, 32'h11});
    @(posedge Uclock);
    #1;
    check("basic_level", PW'(fifo_level), PW'(0));
    check("basic_sb", PW'(exp_q.size()), PW'(0));

    // Backpressure to full FIFO, then a pop that does not unblock the same cycle
    ReceiveReady = 1'b0;
    for (int i = 1; i <= 19; i++) send_word(32'h100 + 32'(i));
    check("bp_level_full", PW'(fifo_level), PW'(4));
    check("bp_ready_low", PW'(in_ready), PW'(0));
    in_valid = 1'b1;
    in_data  = 32'h114;
    repeat (2) @(posedge Uclock);
    #1 ReceiveReady = 1'b1;
    @(negedge Uclock);
    check("full_pop_ready", PW'(in_ready), PW'(0));
    @(posedge Uclock);
    #1 ReceiveReady = 1'b0;
    check("full_pop_level", PW'(fifo_level), PW'(3));
    check("full_pop_ready_next", PW'(in_ready), PW'(1));
    @(posedge Uclock);
    model_accept(32'h114);
    #1 in_valid = 1'b0;
    check("full_push_level", PW'(fifo_level), PW'(4));
    drain();

    // Flush a two-word partial message
    ReceiveReady = 1'b0;
    send_word(32'hA);
    send_word(32'hB);
    flush = 1'b1;
    model_flush();
    @(posedge Uclock);
    #1 flush = 1'b0;
    check("flush_pend_ready", PW'(in_ready), PW'(0));
    check("flush_pend_tr", PW'(TransmitReady), PW'(0));
    @(posedge Uclock);
    #1;
    check("flush_tr", PW'(TransmitReady), PW'(1));
    check("flush_msg", Message, {8'd2, 64'h0, 32'hB, 32'hA});
    check("flush_level", PW'(fifo_level), PW'(1));
    check("flush_ready_back", PW'(in_ready), PW'(1));
    drain();

    // Flush with nothing buffered emits nothing
    flush = 1'b1;
    @(posedge Uclock);
    #1 flush = 1'b0;
    check("flush0_pend_ready", PW'(in_ready), PW'(0));
    @(posedge Uclock);
    #1;
    check("flush0_ready_back", PW'(in_ready), PW'(1));
    check("flush0_tr", PW'(TransmitReady), PW'(0));
    check("flush0_level", PW'(fifo_level), PW'(0));

    // Word arriving with the flush pulse joins the flushed message
    ReceiveReady = 1'b0;
    send_word(32'h5);
    in_valid = 1'b1;
    in_data  = 32'h6;
    flush    = 1'b1;
    @(negedge Uclock);
    check("flushw_ready", PW'(in_ready), PW'(1));
    @(posedge Uclock);
    model_accept(32'h6);
    model_flush();
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    @(posedge Uclock);
    #1;
    check("flushw_tr", PW'(TransmitReady), PW'(1));
    check("flushw_msg", Message, {8'd2, 64'h0, 32'h6, 32'h5});
    drain();

    // Asynchronous reset with buffered and partial data
    ReceiveReady = 1'b0;
    for (int i = 0; i < 14; i++) send_word(32'h200 + 32'(i));
    check("pre_rst_level", PW'(fifo_level), PW'(3));
    #3 Ureset = 1'b0;
    #1;
    check("arst_tr", PW'(TransmitReady), PW'(0));
    check("arst_msg", Message, '0);
    check("arst_level", PW'(fifo_level), PW'(0));
    check("arst_ready", PW'(in_ready), PW'(1));
    exp_q.delete();
    m_fill = 0;
    for (int k = 0; k < 4; k++) m_words[k] = '0;
    @(posedge Uclock);
    #2 Ureset = 1'b1;
    @(posedge Uclock);
    #1;
    ReceiveReady = 1'b1;
    send_word(32'hC1);
    send_word(32'hC2);
    send_word(32'hC3);
    send_word(32'hC4);
    check("post_rst_msg", Message, {8'd4, 32'hC4, 32'hC3, 32'hC2, 32'hC1});
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
